// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: response-owner states and default memory base shared by the arbiter slice
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} owner_e;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
endpackage

// File: rtl/mem_addr_decode.sv
// mem_addr_decode: maps a byte address to a word index and flags range and word alignment
module mem_addr_decode
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = 16_000,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic [31:0]                 addr_i,
    output logic                        in_range_o,
    output logic [$clog2(MEM_SIZE)-1:0] idx_o
);
    localparam int unsigned AW = $clog2(MEM_SIZE);
    localparam logic [32:0] SPAN = 33'(MEM_SIZE) << 2;
    logic [31:0] off;
    assign off        = addr_i - BASE_ADDR;
    assign in_range_o = addr_i >= BASE_ADDR && {1'b0, off} < SPAN && addr_i[1:0] == 2'b00;
    assign idx_o      = off[AW+1:2];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-cycle memory port between fetch and data requesters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_SIZE     = 16_000,
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        if_req,
    input  logic [31:0]                 if_addr,
    output logic                        if_gnt,
    output logic                        if_rvalid,
    output logic [31:0]                 if_rdata,
    output logic                        if_err,
    input  logic                        d_req,
    input  logic                        d_we,
    input  logic [3:0]                  d_be,
    input  logic [31:0]                 d_addr,
    input  logic [31:0]                 d_wdata,
    output logic                        d_gnt,
    output logic                        d_rvalid,
    output logic [31:0]                 d_rdata,
    output logic                        d_err,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [3:0]                  mem_be,
    output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [31:0]                 mem_rdata
);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
    owner_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, rd_q, in_range;
    logic [31:0] gaddr;
    logic [$clog2(MEM_SIZE)-1:0] idx;
    // Data normally wins; a fetch denied STARVE_LIMIT cycles in a row takes the port once.
    assign if_gnt  = !rst && if_req && (!d_req || cnt_q == LIM);
    assign d_gnt   = !rst && d_req && !if_gnt;
    assign gaddr   = d_gnt ? d_addr : if_addr;
    assign cnt_d   = (!if_req || if_gnt) ? '0 : (cnt_q == LIM ? LIM : cnt_q + CW'(1));
    assign state_d = if_gnt ? RESP_IF : (d_gnt ? RESP_D : IDLE);
    mem_addr_decode #(.MEM_SIZE(MEM_SIZE), .BASE_ADDR(BASE_ADDR)) u_dec (
        .addr_i    (gaddr),
        .in_range_o(in_range),
        .idx_o     (idx)
    );
    assign mem_en    = (if_gnt || d_gnt) && in_range;
    assign mem_we    = mem_en && d_gnt && d_we;
    assign mem_be    = mem_en ? (d_gnt ? d_be : 4'hF) : 4'h0;
    assign mem_addr  = mem_en ? idx : '0;
    assign mem_wdata = mem_en ? d_wdata : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= !in_range;
            rd_q    <= !d_we;
        end
    end
    // Gating with rst drops a response whose grant landed just before reset.
    assign if_rvalid = !rst && state_q == RESP_IF;
    assign d_rvalid  = !rst && state_q == RESP_D;
    assign if_err    = if_rvalid && err_q;
    assign d_err     = d_rvalid && err_q;
    assign if_rdata  = (if_rvalid && !err_q) ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !err_q && rd_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario tasks with hand-computed expectations for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst;
    logic if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0] d_be;
    logic if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_wdata;
    logic [3:0] mem_be;
    logic [13:0] mem_addr;
    int errs = 0, n = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        if_req = 0; d_req = 0; d_we = 0; d_be = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic test_reset();
        clear(); rst = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        if_req = 1; d_req = 1; if_addr = 32'h8000_0000; d_addr = 32'h8000_0004;
        d_we = 1; d_be = 4'hF; d_wdata = 32'h1111_2222; #1;
        n++; if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, if_err, d_err} !== 8'h00) begin errs++; $display("FAIL rst_ctrl: got %b exp 00000000", {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, if_err, d_err}); end
        n++; if ({if_rdata, d_rdata, mem_wdata, mem_be, mem_addr} !== '0) begin errs++; $display("FAIL rst_data: got %h %h %h %h %h exp all 0", if_rdata, d_rdata, mem_wdata, mem_be, mem_addr); end
        tick();
        n++; if ({if_rvalid, d_rvalid, if_gnt, d_gnt} !== 4'h0) begin errs++; $display("FAIL rst_hold: got %b exp 0000", {if_rvalid, d_rvalid, if_gnt, d_gnt}); end
        clear(); rst = 0;
        tick();
    endtask

    task automatic test_fetch();
        clear(); if_req = 1; if_addr = 32'h8000_0004; mem_rdata = 0; #1;
        n++; if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010) begin errs++; $display("FAIL fetch_gnt: got %b exp 1010", {if_gnt, d_gnt, mem_en, mem_we}); end
        n++; if ({mem_addr, mem_be} !== {14'd1, 4'hF}) begin errs++; $display("FAIL fetch_mem: got addr %0d be %h exp addr 1 be f", mem_addr, mem_be); end
        tick();
        clear(); d_we = 1; d_be = 4'hF; d_wdata = 32'hA5A5_A5A5; mem_rdata = 32'h0000_0013; #1;
        n++; if ({if_rvalid, if_err, d_rvalid} !== 3'b100) begin errs++; $display("FAIL fetch_resp: got %b exp 100", {if_rvalid, if_err, d_rvalid}); end
        n++; if (if_rdata !== 32'h0000_0013) begin errs++; $display("FAIL fetch_rdata: got %h exp 00000013", if_rdata); end
        n++; if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin errs++; $display("FAIL idle_mem: got en %b we %b be %h addr %0d wdata %h exp all 0", mem_en, mem_we, mem_be, mem_addr, mem_wdata); end
        tick();
        n++; if ({if_rvalid, if_rdata} !== 33'd0) begin errs++; $display("FAIL fetch_oneshot: got rvalid %b rdata %h exp 0 0", if_rvalid, if_rdata); end
        clear();
    endtask

    task automatic test_data();
        clear(); d_req = 1; d_we = 1; d_addr = 32'h8000_0010; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; #1;
        n++; if ({d_gnt, if_gnt, mem_en, mem_we} !== 4'b1011) begin errs++; $display("FAIL wr_gnt: got %b exp 1011", {d_gnt, if_gnt, mem_en, mem_we}); end
        n++; if ({mem_addr, mem_be, mem_wdata} !== {14'd4, 4'b0011, 32'hDEAD_BEEF}) begin errs++; $display("FAIL wr_mem: got addr %0d be %b wdata %h exp 4 0011 deadbeef", mem_addr, mem_be, mem_wdata); end
        tick();
        d_we = 0; d_addr = 32'h8000_0020; d_be = 4'hF; mem_rdata = 32'h1234_5678; #1;
        n++; if ({d_rvalid, d_err, if_rvalid, d_rdata} !== {3'b100, 32'd0}) begin errs++; $display("FAIL wr_resp: got rvalid %b err %b if_rvalid %b rdata %h exp 1 0 0 0", d_rvalid, d_err, if_rvalid, d_rdata); end
        n++; if ({d_gnt, mem_we, mem_addr} !== {2'b10, 14'd8}) begin errs++; $display("FAIL rd_gnt: got gnt %b we %b addr %0d exp 1 0 8", d_gnt, mem_we, mem_addr); end
        tick();
        clear(); mem_rdata = 32'hCAFE_F00D; #1;
        n++; if ({d_rvalid, d_rdata} !== {1'b1, 32'hCAFE_F00D}) begin errs++; $display("FAIL rd_resp: got rvalid %b rdata %h exp 1 cafef00d", d_rvalid, d_rdata); end
        tick();
    endtask

    task automatic test_errors();
        logic        side [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] addr [4] = '{32'h7FFF_FFFC, 32'h8000_FA00, 32'h8000_0002, 32'h8000_F9FC};
        logic        inr  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [13:0] idx  [4] = '{14'd0, 14'd0, 14'd0, 14'd15999};
        for (int i = 0; i < 4; i++) begin
            clear();
            if (side[i]) begin if_req = 1; if_addr = addr[i]; end
            else begin d_req = 1; d_addr = addr[i]; d_be = 4'hF; end
            #1;
            n++; if ({if_gnt, d_gnt} !== {side[i], !side[i]}) begin errs++; $display("FAIL range_gnt[%0d]: got %b exp %b", i, {if_gnt, d_gnt}, {side[i], !side[i]}); end
            n++; if ({mem_en, mem_addr} !== {inr[i], idx[i]}) begin errs++; $display("FAIL range_mem[%0d]: got en %b addr %0d exp en %b addr %0d", i, mem_en, mem_addr, inr[i], idx[i]); end
            tick();
            clear(); mem_rdata = 32'hFFFF_FFFF; #1;
            n++; if ({if_rvalid, if_err, d_rvalid, d_err} !== (side[i] ? {1'b1, !inr[i], 2'b00} : {2'b00, 1'b1, !inr[i]})) begin errs++; $display("FAIL range_resp[%0d]: got %b", i, {if_rvalid, if_err, d_rvalid, d_err}); end
            n++; if ((side[i] ? if_rdata : d_rdata) !== (inr[i] ? 32'hFFFF_FFFF : 32'd0)) begin errs++; $display("FAIL range_rdata[%0d]: got %h exp %h", i, side[i] ? if_rdata : d_rdata, inr[i] ? 32'hFFFF_FFFF : 32'd0); end
        end
        tick();
    endtask

    task automatic test_starve();
        logic [11:0] ifp = 12'b1111_1011_1111;
        logic [11:0] ef  = 12'b1000_0001_0000;
        clear(); d_req = 1; d_addr = 32'h8000_0100; if_addr = 32'h8000_0000;
        for (int c = 0; c < 12; c++) begin
            if_req = ifp[c]; #1;
            n++; if ({if_gnt, d_gnt} !== {ef[c], !ef[c]}) begin errs++; $display("FAIL starve_gnt[%0d]: got %b exp %b", c, {if_gnt, d_gnt}, {ef[c], !ef[c]}); end
            tick();
            mem_rdata = 32'h100 + c; #1;
            n++; if ({if_rvalid, d_rvalid} !== {ef[c], !ef[c]}) begin errs++; $display("FAIL starve_resp[%0d]: got %b exp %b", c, {if_rvalid, d_rvalid}, {ef[c], !ef[c]}); end
            n++; if ((ef[c] ? if_rdata : d_rdata) !== 32'h100 + c) begin errs++; $display("FAIL starve_rdata[%0d]: got %h exp %h", c, ef[c] ? if_rdata : d_rdata, 32'h100 + c); end
        end
        clear();
        tick();
    endtask

    task automatic test_reset_mid();
        clear(); if_req = 1; if_addr = 32'h8000_0008; #1;
        n++; if (if_gnt !== 1'b1) begin errs++; $display("FAIL mid_gnt: got %b exp 1", if_gnt); end
        tick();
        clear(); rst = 1; mem_rdata = 32'h55; #1;
        n++; if ({if_rvalid, d_rvalid, if_rdata} !== 34'd0) begin errs++; $display("FAIL mid_rst_resp: got rvalid %b/%b rdata %h exp 0", if_rvalid, d_rvalid, if_rdata); end
        tick();
        rst = 0; #1;
        n++; if ({if_rvalid, d_rvalid} !== 2'b00) begin errs++; $display("FAIL post_rst_resp: got %b exp 00", {if_rvalid, d_rvalid}); end
        if_req = 1; d_req = 1; d_addr = 32'h8000_0100; if_addr = 32'h8000_0000;
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n++; if (if_gnt !== (c == 4)) begin errs++; $display("FAIL rst_cnt[%0d]: got if_gnt %b exp %b", c, if_gnt, c == 4); end
            tick();
        end
        clear();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] sf = 3'b101;
        for (int c = 0; c < 3; c++) begin
            clear();
            if (sf[c]) begin if_req = 1; if_addr = 32'h8000_0040 + 4 * c; end
            else begin d_req = 1; d_addr = 32'h8000_0040 + 4 * c; d_be = 4'hF; end
            if (c > 0) mem_rdata = 32'hB0 + c - 1;
            #1;
            if (c > 0) begin
                n++; if ({if_rvalid, d_rvalid} !== {sf[c-1], !sf[c-1]}) begin errs++; $display("FAIL b2b_resp[%0d]: got %b exp %b", c - 1, {if_rvalid, d_rvalid}, {sf[c-1], !sf[c-1]}); end
                n++; if ((sf[c-1] ? if_rdata : d_rdata) !== 32'hB0 + c - 1) begin errs++; $display("FAIL b2b_rdata[%0d]: got %h exp %h", c - 1, sf[c-1] ? if_rdata : d_rdata, 32'hB0 + c - 1); end
            end
            n++; if ({if_gnt, d_gnt, mem_addr} !== {sf[c], !sf[c], 14'(16 + c)}) begin errs++; $display("FAIL b2b_gnt[%0d]: got gnt %b addr %0d exp %b %0d", c, {if_gnt, d_gnt}, mem_addr, {sf[c], !sf[c]}, 16 + c); end
            tick();
        end
        clear(); mem_rdata = 32'hB2; #1;
        n++; if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'hB2}) begin errs++; $display("FAIL b2b_last: got %b %h exp 10 000000b2", {if_rvalid, d_rvalid}, if_rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_data();
        test_errors();
        test_starve();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, n);
        $finish;
    end
endmodule
